// File: rtl/lpm_shiftreg_burst.sv
// Parametrised shift register with parallel load, serial in/out, selectable
// direction and shift mode, a counted burst sequencer and an optional output delay line.
module lpm_shiftreg_burst #(
    parameter int               WIDTH  = 16,
    parameter int               CNT_W  = 5,
    parameter int               DELAY  = 0,
    parameter logic [WIDTH-1:0] SVALUE = {WIDTH{1'b1}}
) (
    input  logic             Clock,
    input  logic             Sclr,
    input  logic             Enable,
    input  logic             Sset,
    input  logic             Load,
    input  logic [WIDTH-1:0] Data,
    input  logic             ShiftIn,
    input  logic             Dir,
    input  logic [1:0]       Mode,
    input  logic             Step,
    input  logic             Start,
    input  logic [CNT_W-1:0] Count,
    output logic [WIDTH-1:0] Q,
    output logic             ShiftOut,
    output logic             Busy,
    output logic             Done
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] core_reg;
    logic [WIDTH-1:0] core_next;
    logic [CNT_W-1:0] remaining_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [WIDTH-1:0] q_int;

    // One-step shift of the core, using the live Dir/Mode/ShiftIn.
    always_comb begin
        core_next = core_reg;
        if (!Dir) begin
            if (Mode == 2'b01)
                core_next = {core_reg[WIDTH-2:0], core_reg[WIDTH-1]};
            else
                core_next = {core_reg[WIDTH-2:0], ShiftIn};
        end else begin
            case (Mode)
                2'b01:   core_next = {core_reg[0], core_reg[WIDTH-1:1]};
                2'b10:   core_next = {core_reg[WIDTH-1], core_reg[WIDTH-1:1]};
                default: core_next = {ShiftIn, core_reg[WIDTH-1:1]};
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Sclr) begin
            core_reg      <= '0;
            state_reg     <= IDLE;
            remaining_reg <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else if (Enable) begin
            done_reg <= 1'b0;
            if (Sset || Load) begin
                // Either one aborts a running burst without a completion pulse.
                core_reg      <= Sset ? SVALUE : Data;
                state_reg     <= IDLE;
                busy_reg      <= 1'b0;
                remaining_reg <= '0;
            end else if (state_reg == IDLE) begin
                if (Start) begin
                    if (Count == '0) begin
                        done_reg <= 1'b1;
                    end else begin
                        core_reg <= core_next;
                        if (Count == CNT_W'(1)) begin
                            done_reg <= 1'b1;
                        end else begin
                            state_reg     <= SHIFT;
                            busy_reg      <= 1'b1;
                            remaining_reg <= Count - CNT_W'(1);
                        end
                    end
                end else if (Step) begin
                    core_reg <= core_next;
                end
            end else begin
                core_reg      <= core_next;
                remaining_reg <= remaining_reg - CNT_W'(1);
                if (remaining_reg == CNT_W'(1)) begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                end
            end
        end else begin
            done_reg <= 1'b0;
        end
    end

    generate
        if (DELAY == 0) begin : g_nodelay
            assign q_int = core_reg;
        end else begin : g_delay
            logic [WIDTH-1:0] pipe_reg [DELAY];
            logic [WIDTH-1:0] pipe_in  [DELAY];
            for (genvar gi = 0; gi < DELAY; gi++) begin : g_stage
                if (gi == 0) begin : g_first
                    assign pipe_in[gi] = core_reg;
                end else begin : g_rest
                    assign pipe_in[gi] = pipe_reg[gi-1];
                end
                always_ff @(posedge Clock) begin
                    if (Sclr)
                        pipe_reg[gi] <= '0;
                    else if (Enable)
                        pipe_reg[gi] <= pipe_in[gi];
                end
            end
            assign q_int = pipe_reg[DELAY-1];
        end
    endgenerate

    assign Q        = q_int;
    assign ShiftOut = Dir ? q_int[0] : q_int[WIDTH-1];
    assign Busy     = busy_reg;
    assign Done     = done_reg;

endmodule

// File: tb/tb_lpm_shiftreg_burst.sv
// Bench for lpm_shiftreg_burst: two instances (no delay and two-stage delay) share
// the stimulus and are compared each cycle against a behavioural model.
module tb_lpm_shiftreg_burst;

    localparam logic [15:0] SV = 16'hFFFF;

    logic        Clock = 1'b0;
    logic        Sclr, Enable, Sset, Load, ShiftIn, Dir, Step, Start;
    logic [15:0] Data;
    logic [1:0]  Mode;
    logic [4:0]  Count;
    logic [15:0] q0, q2;
    logic        so0, so2, busy0, busy2, done0, done2;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Behavioural model state.
    logic [15:0] m_core;
    int          m_rem;
    bit          m_busy, m_done;
    logic [15:0] hist[$];

    always #5 Clock = ~Clock;

    lpm_shiftreg_burst #(.WIDTH(16), .CNT_W(5), .DELAY(0), .SVALUE(SV)) u_dut0 (
        .Clock(Clock), .Sclr(Sclr), .Enable(Enable), .Sset(Sset), .Load(Load),
        .Data(Data), .ShiftIn(ShiftIn), .Dir(Dir), .Mode(Mode), .Step(Step),
        .Start(Start), .Count(Count), .Q(q0), .ShiftOut(so0), .Busy(busy0), .Done(done0)
    );

    lpm_shiftreg_burst #(.WIDTH(16), .CNT_W(5), .DELAY(2), .SVALUE(SV)) u_dut2 (
        .Clock(Clock), .Sclr(Sclr), .Enable(Enable), .Sset(Sset), .Load(Load),
        .Data(Data), .ShiftIn(ShiftIn), .Dir(Dir), .Mode(Mode), .Step(Step),
        .Start(Start), .Count(Count), .Q(q2), .ShiftOut(so2), .Busy(busy2), .Done(done2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [15:0] shift_one(input logic [15:0] v, input bit dir,
                                              input logic [1:0] mode, input bit sin);
        if (mode == 2'b01)
            return dir ? ((v >> 1) | (v << 15)) : ((v << 1) | (v >> 15));
        if (!dir)
            return (v << 1) | 16'(sin);
        if (mode == 2'b10)
            return 16'($signed(v) >>> 1);
        return (v >> 1) | (16'(sin) << 15);
    endfunction

    task automatic model_step();
        logic [15:0] sh;
        sh = shift_one(m_core, Dir, Mode, ShiftIn);
        if (Sclr) begin
            m_core = '0; m_rem = 0; m_busy = 0; m_done = 0;
            hist = '{16'h0, 16'h0, 16'h0};
        end else if (!Enable) begin
            m_done = 0;
        end else begin
            m_done = 0;
            if (Sset) begin
                m_core = SV; m_busy = 0;
            end else if (Load) begin
                m_core = Data; m_busy = 0;
            end else if (!m_busy && Start) begin
                if (Count == 0) begin
                    m_done = 1;
                end else begin
                    m_core = sh;
                    m_rem  = int'(Count) - 1;
                    if (m_rem == 0) m_done = 1;
                    else            m_busy = 1;
                end
            end else if (!m_busy && Step) begin
                m_core = sh;
            end else if (m_busy) begin
                m_core = sh;
                m_rem--;
                if (m_rem == 0) begin
                    m_busy = 0; m_done = 1;
                end
            end
            hist.push_front(m_core);
            hist = hist[0:2];
        end
    endtask

    task automatic tick(input string tag);
        @(posedge Clock);
        model_step();
        #1;
        cyc++;
        $display("[%0d] %s en=%b q0=%h q2=%h busy=%b done=%b", cyc, tag, Enable, q0, q2, busy0, done0);
        check("q0", 32'(q0), 32'(m_core));
        check("q2", 32'(q2), 32'(hist[2]));
        check("busy0", 32'(busy0), 32'(m_busy));
        check("busy2", 32'(busy2), 32'(m_busy));
        check("done0", 32'(done0), 32'(m_done));
        check("done2", 32'(done2), 32'(m_done));
        check("so0", 32'(so0), 32'(Dir ? m_core[0] : m_core[15]));
        check("so2", 32'(so2), 32'(Dir ? hist[2][0] : hist[2][15]));
    endtask

    task automatic quiet();
        Sclr = 0; Enable = 1; Sset = 0; Load = 0; Step = 0; Start = 0;
        ShiftIn = 0; Dir = 0; Mode = 2'b00; Count = '0;
    endtask

    task automatic load(input logic [15:0] d);
        quiet(); Load = 1; Data = d; tick("load"); Load = 0;
    endtask

    initial begin
        logic [15:0] frozen;
        m_core = '0; m_rem = 0; m_busy = 0; m_done = 0;
        hist = '{16'h0, 16'h0, 16'h0};
        Data = '0;
        quiet();
        Sclr = 1; tick("reset"); tick("reset"); Sclr = 0;
        check("reset_q", 32'(q0), 32'h0);

        // Reset during a burst with Q all ones.
        Sset = 1; tick("sset"); Sset = 0;
        Start = 1; Count = 5'd10; Mode = 2'b01; tick("start"); Start = 0;
        check("pre_clr_q", 32'(q0), 32'hFFFF);
        check("pre_clr_busy", 32'(busy0), 32'h1);
        Sclr = 1; tick("sclr"); Sclr = 0;
        check("clr_q", 32'(q0), 32'h0);
        check("clr_busy", 32'(busy0), 32'h0);
        check("clr_done", 32'(done0), 32'h0);

        // Single steps in three modes.
        load(16'h8001); ShiftIn = 1; Step = 1; tick("step_logic");
        check("step_logic", 32'(q0), 32'h0003);
        check("step_so", 32'(so0), 32'h0);
        load(16'h8001); Mode = 2'b01; Step = 1; tick("step_rot");
        check("step_rot", 32'(q0), 32'h0003);
        load(16'h8001); Dir = 1; Mode = 2'b10; Step = 1; tick("step_arith");
        check("step_arith", 32'(q0), 32'hC000);

        // Burst of four logical left shifts.
        load(16'h00F0); Start = 1; Count = 5'd4; tick("burst4"); Start = 0;
        for (int i = 0; i < 2; i++) begin
            check("burst4_busy", 32'(busy0), 32'h1);
            tick("burst4");
        end
        check("burst4_busy", 32'(busy0), 32'h1);
        tick("burst4");
        check("burst4_q", 32'(q0), 32'h0F00);
        check("burst4_done", 32'(done0), 32'h1);
        check("burst4_idle", 32'(busy0), 32'h0);
        tick("burst4_after");
        check("burst4_done_once", 32'(done0), 32'h0);

        // Rotate burst of eight with a three-cycle Enable pause.
        load(16'h1234); Start = 1; Count = 5'd8; Mode = 2'b01; tick("rot8"); Start = 0;
        tick("rot8"); tick("rot8");
        frozen = q0;
        Enable = 0;
        for (int i = 0; i < 3; i++) begin
            tick("rot8_pause");
            check("pause_busy", 32'(busy0), 32'h1);
            check("pause_q", 32'(q0), 32'(frozen));
        end
        Enable = 1;
        for (int i = 0; i < 5; i++) tick("rot8");
        check("rot8_q", 32'(q0), 32'h3412);
        check("rot8_done", 32'(done0), 32'h1);

        // Zero-length burst, then a burst aborted by Load.
        quiet(); Start = 1; Count = 5'd0; tick("zero"); Start = 0;
        check("zero_q", 32'(q0), 32'h3412);
        check("zero_done", 32'(done0), 32'h1);
        check("zero_busy", 32'(busy0), 32'h0);
        Start = 1; Count = 5'd5; tick("abort"); Start = 0;
        Load = 1; Data = 16'hBEEF; tick("abort_load"); Load = 0;
        check("abort_q", 32'(q0), 32'hBEEF);
        check("abort_busy", 32'(busy0), 32'h0);
        tick("abort_after");
        check("abort_nodone", 32'(done0), 32'h0);

        // Delay line: load appears two enabled cycles later, Sclr clears it.
        load(16'hA5A5);
        tick("dly"); tick("dly");
        check("dly_q2", 32'(q2), 32'hA5A5);
        load(16'h5A5A); tick("dly");
        Sclr = 1; tick("dly_clr"); Sclr = 0;
        check("dly_clr_q2", 32'(q2), 32'h0);

        // Randomized traffic including long bursts (Count > WIDTH).
        for (int i = 0; i < 1500; i++) begin
            Sclr    = ($urandom_range(0, 99) == 0);
            Enable  = ($urandom_range(0, 99) < 85);
            Sset    = ($urandom_range(0, 49) == 0);
            Load    = ($urandom_range(0, 19) == 0);
            Start   = ($urandom_range(0, 7) == 0);
            Step    = ($urandom_range(0, 3) == 0);
            Data    = 16'($urandom);
            ShiftIn = 1'($urandom);
            Dir     = 1'($urandom);
            Mode    = 2'($urandom_range(0, 3));
            Count   = 5'($urandom_range(0, 31));
            tick("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
